tt_pin_host: RTL
================

Name: tt_pin_host

Overview:
Synthesizable host-side driver for the Tiny Tapeout user-project pin interface. It sits opposite a tt_um-style user design and owns the DUT inputs (ui_in, uio_in, ena, clock enable). It samples the DUT outputs (uo_out, uio_out, uio_oe). A byte-wide command stream with valid/ready controls it, and sampled values return on a valid/ready response stream, so on-chip or FPGA harnesses can exercise a user project without a simulator.

Parameters:
UI_RESET, 8'h00, reset value of dut_ui_in
UIO_RESET, 8'h00, reset value of dut_uio_in

Ports:
clk  input  1  single clock for host and DUT-clock-enable generation
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  host can accept command
cmd_op  input  3  opcode
cmd_data  input  8  command operand
rsp_valid  output  1  response byte present
rsp_ready  input  1  consumer accepts response byte
rsp_data  output  8  response byte
rsp_last  output  1  final byte of a response
dut_ui_in  output  8  drives DUT ui_in
dut_uio_in  output  8  drives DUT uio_in
dut_ena  output  1  drives DUT ena
dut_clk_en  output  1  DUT advances one clk cycle per high cycle
dut_uo_out  input  8  from DUT uo_out
dut_uio_out  input  8  from DUT uio_out
dut_uio_oe  input  8  from DUT uio_oe (1 = DUT drives the bit)
conflict  output  1  sticky flag: host attempted to change a bit the DUT is driving

Behaviour:
- Reset (async, rst_n low): state=IDLE; dut_ui_in=UI_RESET; dut_uio_in=UIO_RESET; dut_ena=0; dut_clk_en=0; rsp_valid=0; rsp_data=0; rsp_last=0; conflict=0; step counter=0. Reset mid-STEP or mid-response aborts immediately. No partial response survives.
- States: IDLE, STEP, RSP0, RSP1. cmd_ready=1 only in IDLE. A command is accepted on a rising edge with cmd_valid&&cmd_ready.
- Opcodes (all take effect on the accept edge; registered outputs update that edge):
  - 0 WRITE_UI: dut_ui_in<=cmd_data. Stays in IDLE, so back-to-back writes run at 1 per cycle.
  - 1 WRITE_UIO: per bit i, if dut_uio_oe[i]=0 then dut_uio_in[i]<=cmd_data[i]; else the bit is unchanged. conflict<=1 if (cmd_data^dut_uio_in)&dut_uio_oe != 0. Stays in IDLE.
  - 2 STEP: counter<=(cmd_data==0)?256:cmd_data (9-bit). Go to STEP. dut_clk_en is registered high for exactly N consecutive cycles, starting the cycle after accept. The counter decrements each cycle; at count 1 the host returns to IDLE and dut_clk_en is low the following cycle. cmd_ready=0 throughout.
  - 3 SAMPLE: capture uo_cap<=dut_uo_out and uio_cap<=dut_uio_out&dut_uio_oe on the accept edge, then go to RSP0.
    - RSP0: rsp_valid=1, rsp_data=uo_cap, rsp_last=0.
    - On handshake go to RSP1: rsp_data=uio_cap, rsp_last=1.
    - On handshake go to IDLE with rsp_valid=0.
    - rsp_data/rsp_last are stable while rsp_valid&&!rsp_ready. Stalls have unbounded length.
  - 4 CTRL: dut_ena<=cmd_data[0]. If cmd_data[1]=1, conflict<=0. If the same accepted command is a clear, clear wins over set (not applicable within one op).
  - 5–7: accepted, no effect, stay IDLE.
- dut_ui_in and dut_uio_in hold their values across STEP and SAMPLE. dut_clk_en is 0 except in STEP.
- dut_ena=0 does not block STEP: clock enable and ena are independent.
- No response is generated except by SAMPLE. Commands are not accepted while a response is pending.

Test Plan:
- Reset with UI_RESET=8'hA5: all outputs at their reset values, dut_ui_in=8'hA5, cmd_ready=1. Assert rst_n low during STEP 10 after 3 enabled cycles -> dut_clk_en=0 and state IDLE immediately.
- WRITE_UI 8'h3C then SAMPLE, with a loopback DUT (uo_out=ui_in, uio_oe=8'h0F, uio_out=8'hFF) -> responses 8'h3C (last=0), then 8'h0F (last=1).
- STEP 5 -> dut_clk_en high exactly 5 cycles starting 1 cycle after accept, cmd_ready low 5 cycles. STEP 0 -> 256 high cycles.
- WRITE_UIO 8'hFF with dut_uio_oe=8'hF0 and dut_uio_in=0 -> dut_uio_in=8'h0F, conflict=1. CTRL 8'h02 -> conflict=0, dut_ena unchanged at 0.
- SAMPLE with rsp_ready held low 20 cycles, then pulsed -> rsp_data stable while stalled, exactly 2 beats, cmd_ready=0 until the final handshake.
- Back-to-back WRITE_UI 8'h01, 8'h02, 8'h03 on consecutive cycles, then opcode 7 -> dut_ui_in tracks each value one cycle after its accept, and opcode 7 changes nothing.

Source files
------------

// File: rtl/tt_pin_host.sv
// Host-side driver for a Tiny Tapeout user-project pin interface: owns the DUT inputs,
// steps the DUT clock enable and returns sampled DUT outputs over a two-beat response stream.
module tt_pin_host #(
    parameter logic [7:0] UI_RESET  = 8'h00,
    parameter logic [7:0] UIO_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_last,
    output logic [7:0] dut_ui_in,
    output logic [7:0] dut_uio_in,
    output logic       dut_ena,
    output logic       dut_clk_en,
    input  logic [7:0] dut_uo_out,
    input  logic [7:0] dut_uio_out,
    input  logic [7:0] dut_uio_oe,
    output logic       conflict
);

    typedef enum logic [1:0] {IDLE, STEP, RSP0, RSP1} state_t;

    typedef enum logic [2:0] {
        OP_WRITE_UI  = 3'd0,
        OP_WRITE_UIO = 3'd1,
        OP_STEP      = 3'd2,
        OP_SAMPLE    = 3'd3,
        OP_CTRL      = 3'd4
    } op_t;

    state_t     state_q;
    logic [8:0] cnt_q;
    logic [7:0] ui_q;
    logic [7:0] uio_q;
    logic       ena_q;
    logic       clk_en_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    logic       rsp_last_q;
    logic       conflict_q;
    logic [7:0] uio_cap_q;

    logic       cmd_fire;
    logic [7:0] uio_d;
    logic       uio_clash;
    logic [8:0] step_cnt_d;

    assign cmd_ready = (state_q == IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;

    // Bits the DUT is driving keep their host value; touching them raises the clash flag.
    always_comb begin
        uio_d      = (uio_q & dut_uio_oe) | (cmd_data & ~dut_uio_oe);
        uio_clash  = |((cmd_data ^ uio_q) & dut_uio_oe);
        step_cnt_d = (cmd_data == 8'd0) ? 9'd256 : {1'b0, cmd_data};
    end

    // NOTE: every state register is cleared by the async reset and assigned with <= only,
    // so a reset mid-STEP or mid-response abandons it in the same instant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 9'd0;
            ui_q        <= UI_RESET;
            uio_q       <= UIO_RESET;
            ena_q       <= 1'b0;
            clk_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_last_q  <= 1'b0;
            conflict_q  <= 1'b0;
            uio_cap_q   <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        case (op_t'(cmd_op))
                            OP_WRITE_UI: ui_q <= cmd_data;
                            OP_WRITE_UIO: begin
                                uio_q <= uio_d;
                                if (uio_clash) conflict_q <= 1'b1;
                            end
                            OP_STEP: begin
                                cnt_q    <= step_cnt_d;
                                clk_en_q <= 1'b1;
                                state_q  <= STEP;
                            end
                            OP_SAMPLE: begin
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= dut_uo_out;
                                rsp_last_q  <= 1'b0;
                                uio_cap_q   <= dut_uio_out & dut_uio_oe;
                                state_q     <= RSP0;
                            end
                            OP_CTRL: begin
                                ena_q <= cmd_data[0];
                                if (cmd_data[1]) conflict_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                STEP: begin
                    if (cnt_q == 9'd1) begin
                        clk_en_q <= 1'b0;
                        cnt_q    <= 9'd0;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 9'd1;
                    end
                end
                RSP0: begin
                    if (rsp_ready) begin
                        rsp_data_q <= uio_cap_q;
                        rsp_last_q <= 1'b1;
                        state_q    <= RSP1;
                    end
                end
                RSP1: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= 8'h00;
                        rsp_last_q  <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_last   = rsp_last_q;
    assign dut_ui_in  = ui_q;
    assign dut_uio_in = uio_q;
    assign dut_ena    = ena_q;
    assign dut_clk_en = clk_en_q;
    assign conflict   = conflict_q;

endmodule
